// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: NZCV flags, carry-chained ADC, valid/ready handshake on both sides.
// Define ALU_PIPE_SAT_EN to make ADD/SUB saturate on signed overflow.
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_ADC = 3'b111
  } op_t;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_t              s1_op;

  logic             adv;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] calc_res;
  logic             calc_c;
  logic             calc_v;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // One extra bit on each shift captures the last bit shifted out as the carry.
  always_comb begin
    amt      = s1_b[SHW-1:0];
    add_b    = (s1_op == OP_SUB) ? ~s1_b : s1_b;
    add_cin  = 1'b0;
    if (s1_op == OP_SUB)
      add_cin = 1'b1;
    else if (s1_op == OP_ADC)
      add_cin = carry_out;
    sum      = {1'b0, s1_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    shl_ext  = {1'b0, s1_a} << amt;
    shr_ext  = {s1_a, 1'b0} >> amt;
    calc_res = '0;
    calc_c   = 1'b0;
    calc_v   = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB, OP_ADC: begin
        calc_res = sum[WIDTH-1:0];
        calc_c   = sum[WIDTH];
        calc_v   = (s1_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_OR:  calc_res = s1_a | s1_b;
      OP_AND: calc_res = s1_a & s1_b;
      OP_XOR: calc_res = s1_a ^ s1_b;
      OP_SHL: begin
        calc_res = shl_ext[WIDTH-1:0];
        calc_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        calc_res = shr_ext[WIDTH:1];
        calc_c   = shr_ext[0];
      end
      default: calc_res = '0;
    endcase
`ifdef ALU_PIPE_SAT_EN
    if ((s1_op == OP_ADD || s1_op == OP_SUB) && calc_v)
      calc_res = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // Flags hold across bubbles so ADC always chains off the last accepted op.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OP_ADD;
      out_valid <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_a      <= num1;
      s1_b      <= num2;
      s1_op     <= op_t'(opcode);
      out_valid <= s1_valid;
      if (s1_valid) begin
        result    <= calc_res;
        negative  <= calc_res[WIDTH-1];
        zero      <= (calc_res == '0);
        carry_out <= calc_c;
        overflow  <= calc_v;
      end
    end
  end

endmodule
